// File: rtl/echo_timer.sv
// echo_timer: ultrasonic ranging controller.
// Fires TRIGGER on start, times the synchronised ECHO high pulse.
module echo_timer #(
  parameter int WIDTH          = 16,
  parameter int TRIG_CYCLES    = 10,
  parameter int TIMEOUT_CYCLES = 60000
) (
  input  logic             CLKOUT,
  input  logic             reset,
  input  logic             start,
  input  logic             ECHO,
  output logic             TRIGGER,
  output logic [WIDTH-1:0] count,
  output logic             calculate,
  output logic             busy,
  output logic             timeout,
  output logic             overflow
);

  localparam int TW = $clog2(TRIG_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TRIG_LAST =
    TW'(TRIG_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST =
    WW'(TIMEOUT_CYCLES - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE
  } state_t;

  state_t           state, state_n;
  logic             echo_m, echo_s;
  logic [TW-1:0]    trig_cnt, trig_cnt_n;
  logic [WW-1:0]    wait_cnt, wait_cnt_n;
  logic [WIDTH-1:0] echo_cnt, echo_cnt_n;
  logic             done;
  logic [WIDTH-1:0] done_count;
  logic             done_to;
  logic             done_ov;

  always_comb begin
    state_n    = state;
    trig_cnt_n = trig_cnt;
    wait_cnt_n = wait_cnt;
    echo_cnt_n = echo_cnt;
    done       = 1'b0;
    done_count = '0;
    done_to    = 1'b0;
    done_ov    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n    = TRIG;
          trig_cnt_n = '0;
          wait_cnt_n = '0;
          echo_cnt_n = '0;
        end
      end
      TRIG: begin
        if (trig_cnt == TRIG_LAST)
          state_n = WAIT_RISE;
        else
          trig_cnt_n = trig_cnt + 1'b1;
      end
      WAIT_RISE: begin
        if (echo_s) begin
          state_n    = MEASURE;
          echo_cnt_n = WIDTH'(1);
        end else if (wait_cnt == WAIT_LAST) begin
          done    = 1'b1;
          done_to = 1'b1;
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
      end
      MEASURE: begin
        if (!echo_s) begin
          done       = 1'b1;
          done_count = echo_cnt;
        end else if (echo_cnt == CNT_MAX) begin
          // saturate instead of wrapping on a stuck echo
          done       = 1'b1;
          done_count = CNT_MAX;
          done_ov    = 1'b1;
        end else begin
          echo_cnt_n = echo_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (done)
      state_n = IDLE;
  end

  always_ff @(posedge CLKOUT) begin
    if (reset) begin
      state     <= IDLE;
      echo_m    <= 1'b0;
      echo_s    <= 1'b0;
      trig_cnt  <= '0;
      wait_cnt  <= '0;
      echo_cnt  <= '0;
      TRIGGER   <= 1'b0;
      busy      <= 1'b0;
      calculate <= 1'b0;
      count     <= '0;
      timeout   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      echo_m    <= ECHO;
      echo_s    <= echo_m;
      trig_cnt  <= trig_cnt_n;
      wait_cnt  <= wait_cnt_n;
      echo_cnt  <= echo_cnt_n;
      TRIGGER   <= (state_n == TRIG);
      busy      <= (state_n != IDLE);
      calculate <= done;
      if (done) begin
        count    <= done_count;
        timeout  <= done_to;
        overflow <= done_ov;
      end
    end
  end

endmodule

// File: doc/echo_timer.md
# echo_timer

Parametrised ultrasonic ranging controller. It generates the sensor TRIGGER pulse on request and synchronises the asynchronous ECHO input. It measures the ECHO high time in clock cycles, and reports the result with a one-cycle `calculate` strobe plus timeout and overflow status. It sits between the ultrasonic sensor pins and the distance-calculation logic, and supersedes the free-running echo counter with a start-driven, bounded-time measurement cycle.

## Interface
- `WIDTH`, 16, width of the echo counter and of `count`; minimum 2.
- `TRIG_CYCLES`, 10, clock cycles TRIGGER is held high; minimum 1.
- `TIMEOUT_CYCLES`, 60000, maximum cycles to wait for ECHO to rise after TRIGGER ends; minimum 1.
- `CLKOUT`  input  1  sole clock; all logic on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request one measurement; sampled only when idle.
- `ECHO`  input  1  sensor echo, asynchronous to CLKOUT.
- `TRIGGER`  output  1  registered sensor trigger pulse.
- `count`  output  WIDTH  last measured ECHO high time in cycles; held until next completion.
- `calculate`  output  1  one-cycle strobe: `count`/`timeout`/`overflow` just updated.
- `busy`  output  1  high whenever the FSM is not IDLE.
- `timeout`  output  1  last measurement saw no echo; held with `count`.
- `overflow`  output  1  last measurement saturated; held with `count`.

## Operation
- ECHO passes through a 2-flop synchroniser (`echo_s`). Nothing else samples raw ECHO.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE.
- **IDLE:** `start`=1 -> TRIG. On that edge: TRIGGER<=1, trigger counter<=0, echo counter<=0, wait counter<=0.
- **TRIG:** TRIGGER stays high for exactly TRIG_CYCLES cycles, then TRIGGER<=0 and the FSM goes to WAIT_RISE.
- **WAIT_RISE:**
  - `echo_s`=1 -> MEASURE with echo counter<=1.
  - Otherwise the wait counter increments. When it reaches TIMEOUT_CYCLES, the measurement completes with `count`<=0, `timeout`<=1, `overflow`<=0.
- **MEASURE:**
  - `echo_s`=1 and counter < 2^WIDTH-1 -> counter increments.
  - `echo_s`=0 -> completes with `count`<=counter and `timeout`=`overflow`=0.
  - Counter = 2^WIDTH-1 with `echo_s` still 1 -> completes with `count`<=2^WIDTH-1 and `overflow`<=1. No wrap-around; a stuck-high ECHO cannot hang the block.
- **Completion** (a single edge): `count`, `timeout`, `overflow` loaded; `calculate`<=1 for one cycle; FSM -> IDLE.
- `start` while `busy`=1 is ignored, not queued.
- `start` on the completion cycle is ignored, because the FSM is not yet IDLE. `start` on the following cycle is accepted.
- Reset values, also applied mid-operation: FSM IDLE, TRIGGER=0, `count`=0, `calculate`=0, `busy`=0, `timeout`=0, `overflow`=0, synchroniser flops=0, internal counters=0.

## Timing
- `start` sampled high at edge S:
  - TRIGGER high from S through S+TRIG_CYCLES.
  - TRIGGER low and WAIT_RISE entered at edge S+TRIG_CYCLES.
  - `busy` high from edge S.
- ECHO sampled high at edges k..k+H-1 (H cycles), low at k+H:
  - MEASURE entered at k+2.
  - Completion at edge k+H+2, giving `count`=H and `calculate` high for the cycle after k+H+2.
- Timeout: completion occurs TIMEOUT_CYCLES cycles after WAIT_RISE is entered, if `echo_s` never rises.
- Fastest restart: `start` held high is accepted every TRIG_CYCLES + 3 + H cycles.
- `busy` deasserts on the completion edge, the same edge that raises `calculate`.
- All outputs are registered; no combinational path from input to output.

## Test plan
- **Normal:** defaults, pulse `start` 1 cycle; ECHO rises 20 cycles after TRIGGER falls, held 100 cycles -> TRIGGER high exactly 10 cycles, `count`=100, `calculate` one cycle 2 edges after the ECHO fall, `timeout`=`overflow`=0.
- **Timeout:** TIMEOUT_CYCLES=50, ECHO never rises -> `calculate` 50 cycles after TRIGGER falls, `count`=0, `timeout`=1, `busy` falls on the same edge.
- **Overflow:** WIDTH=8, ECHO held 300 cycles -> completion after 255 counted cycles, `count`=255, `overflow`=1. Later ECHO activity is ignored until the next `start`.
- **Reset mid-measure:** `reset` 1 cycle at ECHO cycle 40 of a 100-cycle pulse -> all outputs 0 next cycle, no `calculate`. The next `start` measures normally.
- **Start while busy:** `start` pulses during TRIG and MEASURE -> single measurement, single `calculate`.
- **Back-to-back:** `start` held high with ECHO=30, then 60 cycles -> two `calculate` strobes, `count`=30 then 60, `count` held between strobes.
